rate_hex_counter: RTL
=====================

# rate_hex_counter

Rate-divided 4-bit hex counter that produces the nibble consumed by the team's 7-segment hex decoder stage. It divides the board clock into one of four selectable step rates and counts up or down on each step. It supports synchronous parallel load, and emits single-cycle step and wrap pulses for downstream logic. Its `value` output wires directly to the decoder's 4-bit input, and the decoder drives one HEX digit.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz; sets the divisor base. Benches use a small value.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when high, the rate divider runs and the counter may step; when low, both hold.
- `up`  in  1  count direction: 1 = increment, 0 = decrement; sampled on each step.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  4  value written to `value` on `load`.
- `rate_sel`  in  2  step period: 00 = every clock, 01 = CLK_HZ cycles, 10 = 2·CLK_HZ cycles, 11 = 4·CLK_HZ cycles.
- `value`  out  4  current count; feeds the hex decoder input.
- `tick`  out  1  registered pulse, high for exactly one cycle, coincident with each step update of `value`.
- `wrap`  out  1  registered pulse, high together with `tick` when the step crossed 15→0 (up) or 0→15 (down).

## Operation
- Divisor N per `rate_sel`: 1, CLK_HZ, 2·CLK_HZ, 4·CLK_HZ.
- Divider register `rd` has width ceil(log2(4·CLK_HZ)), which is 28 bits at 50 MHz.
- Registered copy `sel_q` of `rate_sel` is used to detect rate changes.
- Reset (asynchronous):
  - value=0, tick=0, wrap=0.
  - sel_q=rate_sel.
  - rd=N(rate_sel)−1.
- Per rising edge, first matching rule wins:
  1. `load`=1:
     - value←load_val; rd←N(rate_sel)−1; sel_q←rate_sel; tick←0; wrap←0.
     - Takes effect regardless of `enable`.
  2. `rate_sel`≠sel_q:
     - sel_q←rate_sel; rd←N(rate_sel)−1; tick←0; wrap←0; value holds.
     - A partially elapsed period is discarded.
  3. `enable`=0:
     - rd and value hold; tick←0; wrap←0.
  4. `enable`=1 and rd≠0:
     - rd←rd−1; tick←0; wrap←0.
  5. `enable`=1 and rd=0 (a step):
     - rd←N(sel_q)−1; tick←1.
     - value←value+1 mod 16 if up, else value−1 mod 16.
     - wrap←1 iff (up and value=15) or (!up and value=0), evaluated on the pre-step value.
- Rate 00: rd stays 0, so every enabled edge is a step; `tick` stays high continuously while enabled.
- Arithmetic is 4-bit modular; there is no saturation.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Step latency:
  - After reset release, or after load or rate change at edge E, with `enable` held high, the first step occurs at edge E+N.
  - From reset release, the first step is the Nth rising edge.
  - Subsequent steps occur every N enabled edges.
- Deasserting `enable` freezes rd. Re-enabling resumes the remaining count; the step is delayed by exactly the number of disabled cycles.
- `up` may change at any time; only its value at the step edge matters.
- Load and step on the same edge: load wins, with no tick and no wrap that cycle.
- Load and rate change on the same edge: both are applied via rule 1.
- Reset mid-period: outputs clear immediately, without waiting for a clock edge. Counting restarts with a full period.
- Every `tick` pulse lasts one cycle, except in rate 00, where it stays continuously high while enabled.
- `wrap` is never high without `tick`.

## Test plan
All scenarios use CLK_HZ=4, so the divisors for rate 01/10/11 are 4, 8 and 16.

- Reset then count up at rate 01:
  - Stimulus: release reset, enable=1, up=1, rate_sel=01.
  - Required: value=1 with tick=1 on edge 4, value=2 on edge 8, tick low on all other cycles.
- Up wrap:
  - Stimulus: load 4'hE, then enable=1, up=1, rate 00.
  - Required: values E, F, 0, 1 on successive edges; wrap=1 only on the F→0 edge.
- Down count with wrap:
  - Stimulus: load 0, up=0, rate 01.
  - Required: value=F with wrap=1 and tick=1 on the 4th edge after the load.
- Enable pause:
  - Stimulus: rate 10; drop enable for 5 cycles after 3 enabled edges.
  - Required: first step occurs 13 edges after the start; value holds and tick=0 while disabled.
- Rate change mid-period:
  - Stimulus: rate 11 for 10 enabled edges, then switch to 01.
  - Required: no step at the switch; next step exactly 4 edges after the switch edge.
- Asynchronous reset and load priority:
  - Stimulus 1: assert reset between edges while value=7. Required: value=0 immediately.
  - Stimulus 2: assert load=1 with load_val=9 on a step edge. Required: value=9, tick=0.

Source files
------------

// File: rtl/rate_hex_counter.sv
// ---------------------------------------------------------------------------
// rate_hex_counter
//
// Rate-divided 4-bit up/down hex counter. The divider selects a step period
// of 1, CLK_HZ, 2*CLK_HZ or 4*CLK_HZ clocks. On every step, the nibble moves
// by one (mod 16). The nibble feeds a 7-segment hex decoder directly.
//
// Ports:
//   clock     in   system clock, rising-edge active
//   reset     in   asynchronous, active-high reset
//   enable    in   runs the divider and allows steps; low freezes both
//   up        in   1 = increment, 0 = decrement (sampled on a step)
//   load      in   synchronous parallel load strobe (highest priority)
//   load_val  in   [3:0] value written on load
//   rate_sel  in   [1:0] step period select (00=1, 01=CLK_HZ, 10=2x, 11=4x)
//   value     out  [3:0] current count
//   tick      out  one-cycle pulse coincident with each step update
//   wrap      out  high with tick when the step crossed 15->0 or 0->15
// ---------------------------------------------------------------------------
module rate_hex_counter #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic [1:0] rate_sel,
   output logic [3:0] value,
   output logic       tick,
   output logic       wrap
);

   // Divider width covers the longest period (4*CLK_HZ - 1).
   localparam int RDW = ($clog2(4 * CLK_HZ) < 1) ? 1 : $clog2(4 * CLK_HZ);

   // Reload value (N - 1) for each rate; rate 00 reloads 0 so every
   // enabled edge is a step.
   logic [RDW-1:0] reload_tab [4];

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_reload
         if (gi == 0) begin : g_every
            assign reload_tab[gi] = '0;
         end else begin : g_div
            assign reload_tab[gi] = RDW'((CLK_HZ << (gi - 1)) - 1);
         end
      end
   endgenerate

   logic [3:0]     value_reg, value_next;
   logic           tick_reg,  tick_next;
   logic           wrap_reg,  wrap_next;
   logic [RDW-1:0] rd_reg,    rd_next;
   logic [1:0]     sel_q_reg, sel_q_next;

   always_comb begin
      value_next = value_reg;
      rd_next    = rd_reg;
      sel_q_next = sel_q_reg;
      tick_next  = 1'b0;
      wrap_next  = 1'b0;

      if (load) begin
         value_next = load_val;
         rd_next    = reload_tab[rate_sel];
         sel_q_next = rate_sel;
      end else if (rate_sel != sel_q_reg) begin
         // New rate: drop whatever part of the old period had elapsed.
         sel_q_next = rate_sel;
         rd_next    = reload_tab[rate_sel];
      end else if (enable) begin
         if (rd_reg != '0) begin
            rd_next = rd_reg - 1'b1;
         end else begin
            rd_next   = reload_tab[sel_q_reg];
            tick_next = 1'b1;
            if (up) begin
               value_next = value_reg + 4'd1;
               wrap_next  = (value_reg == 4'hF);
            end else begin
               value_next = value_reg - 4'd1;
               wrap_next  = (value_reg == 4'h0);
            end
         end
      end
   end

   // The divider restarts from the live rate_sel during reset, so counting
   // after release begins with a full period of the selected rate.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value_reg <= 4'h0;
         tick_reg  <= 1'b0;
         wrap_reg  <= 1'b0;
         sel_q_reg <= rate_sel;
         rd_reg    <= reload_tab[rate_sel];
      end else begin
         value_reg <= value_next;
         tick_reg  <= tick_next;
         wrap_reg  <= wrap_next;
         sel_q_reg <= sel_q_next;
         rd_reg    <= rd_next;
      end
   end

   assign value = value_reg;
   assign tick  = tick_reg;
   assign wrap  = wrap_reg;

endmodule
